// File: rtl/sound_pkg.sv
// sound_pkg: shared types and defaults for the sound RAM arbiter.
//   arb_state_e : ownership handover FSM states
//   host_kind_e : kind of host access held in the slot
//   cnt_w()     : width of a counter that runs 0..n-1
package sound_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int RESET_HOLD_DEF = 4;

  typedef enum logic [2:0] {
    ST_RUN  = 3'd0,
    ST_REQ  = 3'd1,
    ST_OWN  = 3'd2,
    ST_REL  = 3'd3,
    ST_HOLD = 3'd4
  } arb_state_e;

  typedef enum logic {
    HK_RD = 1'b0,
    HK_WR = 1'b1
  } host_kind_e;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/snd_host_slot.sv
// snd_host_slot: single-entry host access slot.
//   Captures one qualified host strobe, issues it to RAM when 'go' allows,
//   returns read data one cycle after issue, and flags strobes it could not take.
// Ports:
//   CLK_32M, RESET_N      clock, async active-low reset
//   host_rd, host_wr      strobes already qualified by HOST_SEL
//   take_ok               arbiter state allows capture
//   host_a, host_din      host address / write data
//   go                    RAM port free for the slot this cycle
//   ram_q                 RAM read data (1-cycle latency)
//   pend                  captured access waiting to issue
//   exec, exec_we         slot drives the RAM port this cycle (and writes)
//   slot_a, slot_d        captured address / data
//   busy, drop            slot occupied / sticky lost-strobe flag
//   dout, dout_valid      read return register and its one-cycle pulse
module snd_host_slot import sound_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK_32M,
  input  logic              RESET_N,
  input  logic              host_rd,
  input  logic              host_wr,
  input  logic              take_ok,
  input  logic [ADDR_W-1:0] host_a,
  input  logic [7:0]        host_din,
  input  logic              go,
  input  logic [7:0]        ram_q,
  output logic              pend,
  output logic              exec,
  output logic              exec_we,
  output logic [ADDR_W-1:0] slot_a,
  output logic [7:0]        slot_d,
  output logic              busy,
  output logic              drop,
  output logic [7:0]        dout,
  output logic              dout_valid
);

  host_kind_e kind;
  logic       rd_wait;
  logic       strobe, take;

  assign strobe  = host_rd | host_wr;
  assign take    = strobe & take_ok & ~busy;
  assign pend    = busy & ~rd_wait;
  assign exec    = pend & go;
  assign exec_we = exec & (kind == HK_WR);

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      busy       <= 1'b0;
      rd_wait    <= 1'b0;
      kind       <= HK_RD;
      slot_a     <= '0;
      slot_d     <= '0;
      drop       <= 1'b0;
      dout       <= 8'hFF;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (strobe && !take) drop <= 1'b1;
      // take needs ~busy and exec/rd_wait need busy, so these are exclusive
      if (take) begin
        busy   <= 1'b1;
        kind   <= host_wr ? HK_WR : HK_RD;  // RD+WR together is a write
        slot_a <= host_a;
        slot_d <= host_din;
      end else if (rd_wait) begin
        dout       <= ram_q;
        dout_valid <= 1'b1;
        busy       <= 1'b0;
        rd_wait    <= 1'b0;
      end else if (exec) begin
        if (kind == HK_WR) busy    <= 1'b0;
        else               rd_wait <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sound_ram_arbiter.sv
// sound_ram_arbiter: owns the single-port sound RAM and shares it between the
// host bus and the sound Z80. Sequences bulk-upload handover
// (BUSRQ -> BUSAK -> host ownership -> release -> Z80 reset hold).
// Build option: SND_ARB_INTERLEAVE_EN -- when defined, host strobes while the
// Z80 runs are served, stretching Z80 memory cycles with WAIT_N if needed.
// Ports:
//   CLK_32M, RESET_N, CE_AUDIO         clock, async reset, Z80 clock enable
//   BRQ                                host bulk-ownership request (level)
//   HOST_SEL/RD/WR/A/DIN               host access; HOST_DOUT/_VALID read return
//   HOST_BUSY, HOST_DROP, GRANT        slot occupied, sticky drop, host owns RAM
//   Z80_A/DO/MREQ_N/RD_N/WR_N/BUSAK_N  Z80 bus in
//   Z80_BUSRQ_N/WAIT_N/RESET_N         Z80 control out; Z80_RAM_Q read data
//   RAM_ADDR/DIN/WE, RAM_Q             RAM port (1-cycle read latency)
module sound_ram_arbiter import sound_pkg::*; #(
  parameter int RESET_HOLD = RESET_HOLD_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              CLK_32M,
  input  logic              RESET_N,
  input  logic              CE_AUDIO,
  input  logic              BRQ,
  input  logic              HOST_SEL,
  input  logic              HOST_RD,
  input  logic              HOST_WR,
  input  logic [ADDR_W-1:0] HOST_A,
  input  logic [7:0]        HOST_DIN,
  output logic [7:0]        HOST_DOUT,
  output logic              HOST_DOUT_VALID,
  output logic              HOST_BUSY,
  output logic              HOST_DROP,
  output logic              GRANT,
  input  logic [ADDR_W-1:0] Z80_A,
  input  logic [7:0]        Z80_DO,
  input  logic              Z80_MREQ_N,
  input  logic              Z80_RD_N,
  input  logic              Z80_WR_N,
  input  logic              Z80_BUSAK_N,
  output logic              Z80_BUSRQ_N,
  output logic              Z80_WAIT_N,
  output logic              Z80_RESET_N,
  output logic [7:0]        Z80_RAM_Q,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [7:0]        RAM_DIN,
  output logic              RAM_WE,
  input  logic [7:0]        RAM_Q
);

  localparam int             CW        = cnt_w(RESET_HOLD);
  localparam logic [CW-1:0]  HOLD_LAST = CW'(RESET_HOLD - 1);

  arb_state_e        st, st_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              z80_live;
  logic              slot_go, take_ok, slot_pend, slot_exec, slot_we;
  logic [ADDR_W-1:0] slot_a;
  logic [7:0]        slot_d;
  logic              z80_wr_act, z80_wr_done, z80_we;
  logic              unused_sink;

  // ---------------- handover FSM ----------------
  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      st  <= ST_HOLD;   // reset behaves like a release: hold Z80 in reset first
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    case (st)
      ST_RUN:  if (BRQ) st_nxt = ST_REQ;
      ST_REQ:  if (!BRQ) st_nxt = ST_RUN;
               else if (!Z80_BUSAK_N) st_nxt = ST_OWN;
      ST_OWN:  if (!BRQ) st_nxt = ST_REL;
      ST_REL:  begin
        st_nxt  = ST_HOLD;
        cnt_nxt = '0;
      end
      ST_HOLD: begin
        if (BRQ) begin
          st_nxt  = ST_REQ;
          cnt_nxt = '0;
        end else if (CE_AUDIO) begin
          if (cnt == HOLD_LAST) begin
            st_nxt  = ST_RUN;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: st_nxt = ST_HOLD;
    endcase
  end

  // Z80 keeps driving the bus until it acknowledges, so REQ counts as live
  assign z80_live    = (st == ST_RUN) | (st == ST_REQ);
  assign GRANT       = (st == ST_OWN);
  assign Z80_BUSRQ_N = ~((st == ST_REQ) | (st == ST_OWN));
  assign Z80_RESET_N = ~((st == ST_OWN) | (st == ST_REL) | (st == ST_HOLD));

  // ---------------- host slot gating ----------------
`ifdef SND_ARB_INTERLEAVE_EN
  logic wait_q;

  // Stall the Z80 at its next clock enable, keep it stalled until the slot
  // drains, so RAM_Q is back on Z80_A before WAIT_N releases.
  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N)                     wait_q <= 1'b0;
    else if (!z80_live || !HOST_BUSY) wait_q <= 1'b0;
    else if (slot_pend && !Z80_MREQ_N && CE_AUDIO) wait_q <= 1'b1;
  end

  assign slot_go    = ~z80_live | Z80_MREQ_N | wait_q;
  assign take_ok    = (st == ST_OWN) | (st == ST_RUN);
  assign Z80_WAIT_N = ~wait_q;
`else
  // Outside OWN the slot only finds the RAM free while the Z80 is held off
  assign slot_go    = ~z80_live;
  assign take_ok    = (st == ST_OWN);
  assign Z80_WAIT_N = 1'b1;
`endif

  snd_host_slot #(.ADDR_W(ADDR_W)) u_slot (
    .CLK_32M   (CLK_32M),
    .RESET_N   (RESET_N),
    .host_rd   (HOST_SEL & HOST_RD),
    .host_wr   (HOST_SEL & HOST_WR),
    .take_ok   (take_ok),
    .host_a    (HOST_A),
    .host_din  (HOST_DIN),
    .go        (slot_go),
    .ram_q     (RAM_Q),
    .pend      (slot_pend),
    .exec      (slot_exec),
    .exec_we   (slot_we),
    .slot_a    (slot_a),
    .slot_d    (slot_d),
    .busy      (HOST_BUSY),
    .drop      (HOST_DROP),
    .dout      (HOST_DOUT),
    .dout_valid(HOST_DOUT_VALID)
  );

  // ---------------- Z80 write edge ----------------
  // One RAM write per Z80 write cycle; if the slot holds the port on the
  // first cycle, the write slides to the next free cycle.
  assign z80_wr_act = ~Z80_MREQ_N & ~Z80_WR_N;
  assign z80_we     = z80_live & z80_wr_act & ~z80_wr_done & ~slot_exec;

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) z80_wr_done <= 1'b0;
    else          z80_wr_done <= z80_wr_act & (z80_wr_done | z80_we);
  end

  // ---------------- RAM port mux ----------------
  always_comb begin
    RAM_ADDR = '0;
    RAM_DIN  = '0;
    RAM_WE   = 1'b0;
    if (slot_exec) begin
      RAM_ADDR = slot_a;
      RAM_DIN  = slot_d;
      RAM_WE   = slot_we;
    end else if (z80_live) begin
      RAM_ADDR = Z80_A;
      RAM_DIN  = Z80_DO;
      RAM_WE   = z80_we;
    end
  end

  assign Z80_RAM_Q = RAM_Q;

  // Z80 reads need only the address mux; RD_N is observed but not decoded
  assign unused_sink = ^{Z80_RD_N, slot_pend};

endmodule

// File: doc/sound_ram_arbiter.md
# sound_ram_arbiter

Owns the 64 KiB sound RAM port and shares it between the main-CPU host bus and the sound Z80. Sequences the bulk-upload handover: bus request, Z80 bus acknowledge, host ownership, release, and post-release Z80 reset hold. Optionally interleaves single host accesses into a running Z80 by stretching Z80 cycles with WAIT_n. Sits between the host bus decode, the T80 core and the single-port sound RAM.

## Interface
- RESET_HOLD, 4: CE_AUDIO ticks Z80_RESET_N stays low after host releases the bus
- ADDR_W, 16: RAM address width
- CLK_32M  in  1  system clock
- RESET_N  in  1  asynchronous, active-low reset
- CE_AUDIO  in  1  Z80 clock enable
- BRQ  in  1  host bulk-ownership request (level)
- HOST_SEL  in  1  host access targets sound RAM
- HOST_RD, HOST_WR  in  1  host strobes, one cycle, qualified by HOST_SEL
- HOST_A  in  ADDR_W  host address
- HOST_DIN  in  8  host write data
- HOST_DOUT  out  8  host read data
- HOST_DOUT_VALID  out  1  one-cycle pulse, read data valid
- HOST_BUSY  out  1  access slot occupied
- HOST_DROP  out  1  sticky: strobe arrived while busy/not servable; cleared by reset only
- GRANT  out  1  host owns RAM
- Z80_A  in  ADDR_W; Z80_DO  in  8; Z80_MREQ_N, Z80_RD_N, Z80_WR_N, Z80_BUSAK_N  in  1
- Z80_BUSRQ_N, Z80_WAIT_N, Z80_RESET_N  out  1
- Z80_RAM_Q  out  8  RAM read data to Z80 input mux
- RAM_ADDR  out  ADDR_W; RAM_DIN  out  8; RAM_WE  out  1; RAM_Q  in  8 (1-cycle read latency)

## Operation
- FSM states: RUN, REQ, OWN, REL, HOLD.
- RUN: RAM_ADDR = Z80_A; RAM_WE = 1 for exactly one CLK_32M cycle per Z80 write, the first cycle where ~MREQ_N & ~WR_N; Z80_RAM_Q = RAM_Q.
- RUN -> REQ on BRQ=1: Z80_BUSRQ_N=0.
- REQ -> OWN when Z80_BUSAK_N=0 and BRQ=1. REQ -> RUN when BRQ drops first; BUSRQ_N released next cycle.
- OWN: GRANT=1, Z80_RESET_N=0. Host accesses are executed directly; Z80 signals ignored.
- OWN -> REL on BRQ=0. REL lasts one cycle: BUSRQ_N=1, GRANT=0.
- REL -> HOLD, then count RESET_HOLD CE_AUDIO ticks with Z80_RESET_N=0. HOLD -> RUN on count expiry.
- BRQ=1 during HOLD: go to REQ and abandon the count.
- Host strobe with no access pending and state OWN (or RUN with interleave enabled) is captured into the slot; HOST_BUSY=1.
- Any other host strobe sets HOST_DROP and is otherwise ignored. A simultaneous RD and WR counts as a write.
- Write: RAM_WE=1 for one cycle, RAM_ADDR=HOST_A, RAM_DIN=HOST_DIN.
- Read: present the address, capture RAM_Q the cycle after, pulse HOST_DOUT_VALID.
- Reset values: GRANT=0, Z80_BUSRQ_N=1, Z80_WAIT_N=1, Z80_RESET_N=0 (held RESET_HOLD ticks, then RUN), RAM_WE=0, RAM_ADDR=0, HOST_DOUT=8'hFF, HOST_DOUT_VALID=0, HOST_BUSY=0, HOST_DROP=0.
- An asynchronous reset mid-access aborts the access and performs no RAM write.

## Timing
- Host strobe at cycle N in OWN: RAM_WE/RAM_ADDR at N+1.
- Read: RAM_Q sampled at N+2; HOST_DOUT and HOST_DOUT_VALID at N+3. HOST_BUSY clears at N+2 (write) or N+3 (read).
- Back-to-back host strobes every 2 cycles (writes) or 3 cycles (reads) are lossless.
- BRQ to Z80_BUSRQ_N low: 1 cycle. BUSAK_N low to GRANT: 1 cycle.
- Z80 write: RAM_WE asserted the cycle after WR_N falls, with MREQ_N low.

## Configuration
- SND_ARB_INTERLEAVE_EN defined: host strobes in RUN are served.
  - If Z80_MREQ_N=1, the slot executes immediately.
  - Otherwise Z80_WAIT_N goes low at the next CE_AUDIO. The host access executes, then WAIT_N releases. The Z80 write edge still issues exactly one RAM_WE after the wait.
- Undefined: strobes outside OWN set HOST_DROP; Z80_WAIT_N is tied to 1.

## Structure
- Package sound_pkg: FSM state enum, default ADDR_W, RESET_HOLD, host access-kind enum.
- Sub-module snd_host_slot: strobe capture, busy flag, drop flag, read-data return register.

## Test plan
- Reset release: Z80_RESET_N low for 4 CE_AUDIO ticks, then high. All other outputs at their reset values.
- BRQ=1, BUSAK_N low 5 cycles later: BUSRQ_N low at +1, GRANT at BUSAK+1. Write 8'hA5 to 16'h1234, then read it back: HOST_DOUT=8'hA5 at strobe+3.
- BRQ pulse of 2 cycles with BUSAK_N never low: return to RUN, BUSRQ_N=1, GRANT never asserted.
- Host write strobes at N and N+1 in OWN: first write performed, HOST_DROP=1, RAM holds only the first value.
- Interleave enabled: Z80 reads 16'h0100 while host writes 8'h3C to 16'h0200. WAIT_N low, then released; RAM[16'h0200]=8'h3C; Z80 read data unaffected.
- RESET_N asserted mid host write (cycle N+0): no RAM_WE, GRANT=0, HOST_BUSY=0.
